if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly upstream of decode and of the hazard unit.
- Owns the fetch PC and the instruction-memory request handshake (one outstanding request).
- Consumes stall, flush_IFID, branch_taken/target, trap_taken/trap vector and mret_taken/mepc; delivers pc_ID, inst_ID and valid_ID to decode.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INST, 32'h0000_0013, encoding injected on flush or bubble (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold IF/ID contents and fetch PC.
- flush_IFID  in  1  replace IF/ID contents with bubble.
- branch_taken  in  1  redirect fetch to branch_target.
- branch_target  in  32  branch/jal/jalr target.
- trap_taken  in  1  redirect fetch to trap_vector.
- trap_vector  in  32  mtvec base.
- mret_taken  in  1  redirect fetch to mepc.
- mepc  in  32  return address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- pc_ID  out  32  PC of instruction in ID.
- inst_ID  out  32  instruction in ID.
- valid_ID  out  1  inst_ID is a real instruction.

Behaviour:
- Reset (rst_n=0 at edge) sets the following:
  - pc_IF=RESET_PC; state=REQ; kill=0; skid buffer empty.
  - pc_ID=0; inst_ID=NOP_INST; valid_ID=0.
  - imem_req is 0 during reset and in the first cycle after it, then 1.
  - Reset mid-transaction drops the outstanding response: kill is cleared, and an rvalid arriving in REQ is ignored.
- imem_addr = {pc_IF[31:2],2'b00}.
- States:
  - REQ: imem_req=1. On imem_gnt go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - kill=1: drop the word, clear kill, go to REQ.
    - Otherwise, stall=0: load IF/ID, pc_IF+=4, go to REQ.
    - Otherwise, stall=1: capture word and pc into skid, go to HOLD.
  - HOLD: imem_req=0. When stall=0: load IF/ID from skid, pc_IF+=4, go to REQ.
- Latency: a granted request with rvalid N cycles later puts the instruction in IF/ID at the edge of the rvalid cycle. Steady-state throughput is one instruction per (1+N) cycles; no prefetch.
- IF/ID update priority, per edge:
  1. flush_IFID=1 → inst_ID=NOP_INST, valid_ID=0, pc_ID unchanged. This wins over stall.
  2. stall=1 → hold.
  3. New word available → load it, valid_ID=1.
  4. Otherwise → bubble (NOP_INST, valid_ID=0).
- Redirect priority: trap_taken > mret_taken > branch_taken. The target has bits[1:0] forced to 0.
  - Redirect overrides stall for pc_IF.
  - In REQ without grant: pc_IF=target; stay in REQ.
  - In REQ with grant the same cycle: pc_IF=target, kill=1, go to WAIT.
  - In WAIT: pc_IF=target, kill=1. If rvalid arrives that same cycle, drop it, clear kill and go to REQ.
  - In HOLD: discard skid, pc_IF=target, go to REQ.
  - A word arriving in the redirect cycle is never written to IF/ID.
- pc_IF wraps modulo 2^32 (32'hFFFF_FFFC+4=0).
- Responses arriving in REQ are protocol violations and are ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_wait_cycles (32 bits).
  - perf_fetched increments on each IF/ID load with valid_ID=1.
  - perf_wait_cycles increments on each cycle in REQ or WAIT.
  - Both reset to 0, saturate at all-ones, and are unaffected by stall.
- Undefined: no counters, no extra ports.

Decomposition:
- Shared cpu package holds:
  - state typedef (REQ, WAIT, HOLD);
  - NOP encoding;
  - reset-PC constant;
  - redirect-select encoding.
- One natural sub-module: if_redirect_mux, the combinational priority select of next pc_IF among trap, mret, branch, pc+4 and hold.

Test Plan:
- Reset release, imem grants immediately, rvalid 1 cycle later → addresses 0,4,8 fetched; valid_ID=1 every 2 cycles; pc_ID 0,4,8.
- rvalid arrives while stall=1 for 3 cycles → HOLD entered. inst_ID holds for 3 cycles, then the skid word loads; no word is lost or duplicated.
- branch_taken=1, target 0x103 during WAIT → next rvalid dropped, next imem_addr=0x100, valid_ID=0 for that slot.
- trap_taken, mret_taken and branch_taken asserted together, trap_vector=0x80 → imem_addr=0x80 and IF/ID flushed.
- stall=1 with flush_IFID=1 → inst_ID=0x00000013, valid_ID=0.
- pc_IF=0xFFFFFFFC fetch completes → next imem_addr=0x0. With FETCH_PERF_EN, perf_fetched increments by 1.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Imported by if_fetch_unit and if_redirect_mux.
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_PC4,
    SEL_BRANCH,
    SEL_MRET,
    SEL_TRAP
  } redir_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_redirect_mux.sv
// Next fetch-PC select: trap > mret > branch > pc+4 > hold.
// Redirect targets are forced to word alignment.
module if_redirect_mux
  import if_fetch_unit_pkg::*;
(
  input  logic        trap_taken,
  input  logic [31:0] trap_vector,
  input  logic        mret_taken,
  input  logic [31:0] mepc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        advance,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next
);

  redir_sel_t sel;

  always_comb begin
    if (trap_taken)        sel = SEL_TRAP;
    else if (mret_taken)   sel = SEL_MRET;
    else if (branch_taken) sel = SEL_BRANCH;
    else if (advance)      sel = SEL_PC4;
    else                   sel = SEL_HOLD;
  end

  always_comb begin
    pc_next = pc_cur;
    unique case (sel)
      SEL_TRAP:   pc_next = word_align(trap_vector);
      SEL_MRET:   pc_next = word_align(mepc);
      SEL_BRANCH: pc_next = word_align(branch_target);
      SEL_PC4:    pc_next = pc_cur + 32'd4;
      default:    pc_next = pc_cur;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage + IF/ID register, one outstanding imem request.
// Define FETCH_PERF_EN for perf_fetched / perf_wait_cycles counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush_IFID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_vector,
  input  logic        mret_taken,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait_cycles
`endif
);

  fetch_state_t state, state_n;
  logic         kill, kill_n;
  logic         started;
  logic [31:0]  pc_if, pc_next;
  logic [31:0]  skid_pc, skid_inst;
  logic         redirect, advance;
  logic         load_new, load_skid, skid_cap;
  logic         has_word, id_load;
  if_id_t       if_id, word;

  assign redirect = trap_taken | mret_taken | branch_taken;

  if_redirect_mux u_redirect_mux (
    .trap_taken    (trap_taken),
    .trap_vector   (trap_vector),
    .mret_taken    (mret_taken),
    .mepc          (mepc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .advance       (advance),
    .pc_cur        (pc_if),
    .pc_next       (pc_next)
  );

  // started masks the request for one cycle after reset release
  assign imem_req  = rst_n & started & (state == REQ);
  assign imem_addr = word_align(pc_if);

  always_comb begin
    state_n   = state;
    kill_n    = kill;
    advance   = 1'b0;
    load_new  = 1'b0;
    load_skid = 1'b0;
    skid_cap  = 1'b0;
    unique case (state)
      REQ: begin
        if (imem_req && imem_gnt) begin
          state_n = WAIT;
          kill_n  = redirect;
        end
      end
      WAIT: begin
        if (redirect) begin
          kill_n = ~imem_rvalid;
          if (imem_rvalid) state_n = REQ;
        end else if (imem_rvalid) begin
          kill_n = 1'b0;
          if (kill) begin
            state_n = REQ;
          end else if (stall) begin
            state_n  = HOLD;
            skid_cap = 1'b1;
          end else begin
            state_n  = REQ;
            load_new = 1'b1;
            advance  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          state_n = REQ;
        end else if (!stall) begin
          state_n   = REQ;
          load_skid = 1'b1;
          advance   = 1'b1;
        end
      end
      default: state_n = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= REQ;
      kill    <= 1'b0;
      started <= 1'b0;
      pc_if   <= RESET_PC;
    end else begin
      state   <= state_n;
      kill    <= kill_n;
      started <= 1'b1;
      pc_if   <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_cap) begin
      skid_pc   <= pc_if;
      skid_inst <= imem_rdata;
    end
  end

  assign has_word = load_new | load_skid;
  assign id_load  = has_word & ~flush_IFID & ~stall;

  always_comb begin
    word.valid = 1'b1;
    word.pc    = load_new ? pc_if : skid_pc;
    word.inst  = load_new ? imem_rdata : skid_inst;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id.pc    <= '0;
      if_id.inst  <= NOP_INST;
      if_id.valid <= 1'b0;
    end else if (flush_IFID) begin
      if_id.inst  <= NOP_INST;
      if_id.valid <= 1'b0;
    end else if (!stall) begin
      if (has_word) begin
        if_id <= word;
      end else begin
        if_id.inst  <= NOP_INST;
        if_id.valid <= 1'b0;
      end
    end
  end

  assign pc_ID    = if_id.pc;
  assign inst_ID  = if_id.inst;
  assign valid_ID = if_id.valid;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched     <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (id_load && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (state != HOLD && perf_wait_cycles != '1)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`else
  logic unused_id_load;
  assign unused_id_load = id_load;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed plan items plus randomized
// traffic against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush_IFID = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        trap_taken = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        mret_taken = 1'b0;
  logic [31:0] mepc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_ID, inst_ID;
  logic        valid_ID;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_wait_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush_IFID    (flush_IFID),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap_taken    (trap_taken),
    .trap_vector   (trap_vector),
    .mret_taken    (mret_taken),
    .mepc          (mepc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .pc_ID         (pc_ID),
    .inst_ID       (inst_ID),
    .valid_ID      (valid_ID)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where the fetcher is in its transaction and
  // what decode must see.
  logic [31:0] m_pc;
  bit          m_started, m_busy, m_doomed, m_parked;
  logic [31:0] m_park_pc, m_park_inst;
  logic [31:0] e_pc, e_inst;
  bit          e_valid;
  logic [31:0] m_fetched, m_wait;

  function automatic bit exp_req();
    return rst_n && m_started && !m_busy && !m_parked;
  endfunction

  task automatic model_step();
    logic [31:0] tgt, gpc, ginst;
    bit redir, got;
    if (!rst_n) begin
      m_pc = 32'h0; m_started = 0; m_busy = 0; m_doomed = 0;
      m_parked = 0; e_pc = 0; e_inst = NOP; e_valid = 0;
      m_fetched = 0; m_wait = 0;
      return;
    end
    redir = trap_taken || mret_taken || branch_taken;
    tgt = trap_taken ? trap_vector : mret_taken ? mepc : branch_target;
    tgt = tgt & 32'hFFFF_FFFC;
    got = 0; gpc = 0; ginst = 0;
    if (!m_parked && m_wait != 32'hFFFF_FFFF) m_wait = m_wait + 1;
    if (!m_busy && !m_parked) begin
      if (exp_req() && imem_gnt) begin
        m_busy = 1; m_doomed = redir;
      end
      if (redir) m_pc = tgt;
    end else if (m_busy) begin
      if (redir) begin
        m_pc = tgt;
        if (imem_rvalid) begin m_busy = 0; m_doomed = 0; end
        else m_doomed = 1;
      end else if (imem_rvalid) begin
        m_busy = 0;
        if (m_doomed) m_doomed = 0;
        else if (!stall) begin
          got = 1; gpc = m_pc; ginst = imem_rdata; m_pc = m_pc + 4;
        end else begin
          m_parked = 1; m_park_pc = m_pc; m_park_inst = imem_rdata;
        end
      end
    end else begin
      if (redir) begin
        m_parked = 0; m_pc = tgt;
      end else if (!stall) begin
        m_parked = 0; got = 1; gpc = m_park_pc; ginst = m_park_inst;
        m_pc = m_pc + 4;
      end
    end
    if (flush_IFID) begin
      e_inst = NOP; e_valid = 0;
    end else if (!stall) begin
      if (got) begin
        e_pc = gpc; e_inst = ginst; e_valid = 1;
        if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
      end else begin
        e_inst = NOP; e_valid = 0;
      end
    end
    m_started = 1;
  endtask

  // Memory responder: grants only when a request is expected,
  // answers after a random latency, keeps answering across resets.
  int          lat_min = 1, lat_max = 1, gnt_pct = 100;
  bit          r_busy = 0;
  int          r_cnt = 0;
  logic [31:0] r_addr = '0, g_addr = '0;

  task automatic mem_step();
    if (imem_rvalid) r_busy = 0;
    if (imem_gnt) begin
      r_busy = 1;
      r_cnt  = $urandom_range(lat_max, lat_min);
      r_addr = g_addr;
    end
  endtask

  task automatic mem_drive();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
    if (r_busy) begin
      r_cnt--;
      if (r_cnt <= 0) begin
        imem_rvalid = 1; imem_rdata = mem_word(r_addr);
      end
    end else if (exp_req() && $urandom_range(99, 0) < gnt_pct) begin
      imem_gnt = 1; g_addr = m_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic compare();
    chk("imem_req", imem_req, exp_req());
    chk("imem_addr", imem_addr, m_pc & 32'hFFFF_FFFC);
    chk("valid_ID", valid_ID, e_valid);
    chk("pc_ID", pc_ID, e_pc);
    chk("inst_ID", inst_ID, e_inst);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_wait_cycles", perf_wait_cycles, m_wait);
`endif
  endtask

  task automatic step();
    mem_drive();
    @(posedge clk);
    model_step();
    mem_step();
    #1;
    compare();
  endtask

  task automatic run_until_valid(input string name);
    int n = 0;
    do begin
      step(); n++;
    end while (!e_valid && n < 40);
    if (!e_valid) begin
      checks++; errors++;
      $display("FAIL %s: no valid instruction within %0d cycles", name, n);
    end
  endtask

  logic [31:0] q[$];
  logic [31:0] fetched0;

  initial begin
    rst_n = 0;
    repeat (3) step();
    chk("rst_valid", valid_ID, 0);
    chk("rst_inst", inst_ID, NOP);
    chk("rst_pc", pc_ID, 0);
    chk("rst_req", imem_req, 0);
    rst_n = 1;
    #1;
    chk("req_first_cycle", imem_req, 0);

    // back-to-back fetch, 1-cycle latency
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) chk("req_after_first", imem_req, 1);
      if (valid_ID) q.push_back(pc_ID);
    end
    chk("t1_count", q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t1_pc", (q.size() > i) ? q[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // stall across the response: skid then release
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_pc", pc_ID, 32'h8);
      chk("t2_hold_inst", inst_ID, mem_word(32'h8));
      chk("t2_hold_req", imem_req, 0);
    end
    stall = 0;
    step();
    chk("t2_skid_pc", pc_ID, 32'hC);
    chk("t2_skid_valid", valid_ID, 1);
    chk("t2_next_addr", imem_addr, 32'h10);
    run_until_valid("t2_next");
    chk("t2_next_pc", pc_ID, 32'h10);

    // branch in WAIT kills the in-flight word
    lat_min = 2; lat_max = 2;
    step();
    branch_taken = 1; branch_target = 32'h103;
    step();
    branch_taken = 0;
    chk("t3_addr", imem_addr, 32'h100);
    step();
    chk("t3_drop_valid", valid_ID, 0);
    chk("t3_req", imem_req, 1);
    lat_min = 1; lat_max = 1;
    run_until_valid("t3_target");
    chk("t3_pc", pc_ID, 32'h100);
    chk("t3_inst", inst_ID, mem_word(32'h100));

    // simultaneous redirects: trap wins
    trap_taken = 1; trap_vector = 32'h80;
    mret_taken = 1; mepc = 32'h200;
    branch_taken = 1; branch_target = 32'h300;
    flush_IFID = 1;
    step();
    trap_taken = 0; mret_taken = 0; branch_taken = 0; flush_IFID = 0;
    chk("t4_addr", imem_addr, 32'h80);
    chk("t4_valid", valid_ID, 0);
    chk("t4_inst", inst_ID, NOP);
    run_until_valid("t4_target");
    chk("t4_pc", pc_ID, 32'h80);

    // flush beats stall
    stall = 1; flush_IFID = 1;
    step();
    stall = 0; flush_IFID = 0;
    chk("t5_inst", inst_ID, 32'h0000_0013);
    chk("t5_valid", valid_ID, 0);

    // PC wrap at top of address space
    branch_taken = 1; branch_target = 32'hFFFF_FFFE;
    step();
    branch_taken = 0;
    fetched0 = m_fetched;
    run_until_valid("t6_wrap");
    chk("t6_pc", pc_ID, 32'hFFFF_FFFC);
    chk("t6_next_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("t6_perf", perf_fetched, fetched0 + 1);
`else
    chk("t6_count", m_fetched, fetched0 + 1);
`endif

    // randomized traffic, including mid-run resets
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 4000; i++) begin
      rst_n         = ($urandom_range(299, 0) != 0);
      stall         = ($urandom_range(99, 0) < 30);
      flush_IFID    = ($urandom_range(99, 0) < 6);
      trap_taken    = ($urandom_range(99, 0) < 3);
      mret_taken    = ($urandom_range(99, 0) < 3);
      branch_taken  = ($urandom_range(99, 0) < 6);
      trap_vector   = $urandom;
      mepc          = $urandom;
      branch_target = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
